// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MULT/MULTU: one partial product per clock,
// with sign handled by multiplying magnitudes and negating the product at the end.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q, done_q;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] addend, result;

  // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps to 2^(WIDTH-1).
  assign mag_a  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
  assign result = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_ITER) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        S_RUN: begin
          if (mplier_q[0]) acc_q <= acc_q + addend;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        S_FIX: begin
          {hi_q, lo_q} <= result;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: 32-bit and 8-bit instances checked against a
// plain-arithmetic product model, including latency, ignored starts and abort.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0, signed32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0, signed8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(signed32),
    .op_a(a32), .op_b(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  seq_multiplier #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(signed8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full product via sign/zero extension and ordinary multiplication.
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [15:0] ea, eb;
    ea = s ? {{8{a[7]}}, a} : {8'b0, a};
    eb = s ? {{8{b[7]}}, b} : {8'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  // inject_at > 0 raises a 2x2 start for one edge while busy.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int inject_at, input string tag);
    logic [63:0] exp;
    int edges;
    exp = ref32(a, b, s);
    start32 = 1'b1; a32 = a; b32 = b; signed32 = s;
    @(posedge clk);
    @(negedge clk);
    edges = 1;
    start32 = 1'b0; a32 = $urandom; b32 = $urandom; signed32 = 1'($urandom_range(0, 1));
    check({tag, "_busy"}, 64'(busy32), 64'd1);
    check({tag, "_done_low"}, 64'(done32), 64'd0);
    while (!done32 && edges < 200) begin
      if (edges == inject_at) begin
        start32 = 1'b1; a32 = 32'd2; b32 = 32'd2; signed32 = 1'b0;
      end else begin
        start32 = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start32 = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'd34);
    check({tag, "_busy_done"}, 64'(busy32), 64'd0);
    check({tag, "_prod"}, {hi32, lo32}, exp);
    $display("op32 %-10s a=%08h b=%08h s=%0d -> hi=%08h lo=%08h edges=%0d",
             tag, a, b, s, hi32, lo32, edges);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input string tag);
    logic [15:0] exp;
    int edges;
    exp = ref8(a, b, s);
    start8 = 1'b1; a8 = a; b8 = b; signed8 = s;
    @(posedge clk);
    @(negedge clk);
    edges = 1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 64'(edges), 64'd10);
    check({tag, "_busy_done"}, 64'(busy8), 64'd0);
    check({tag, "_prod"}, 64'({hi8, lo8}), 64'(exp));
    $display("op8  %-10s a=%02h b=%02h s=%0d -> hi=%02h lo=%02h edges=%0d",
             tag, a, b, s, hi8, lo8, edges);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_prod32", {hi32, lo32}, 64'd0);
    check("rst_prod8", 64'({busy8, done8, hi8, lo8}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    op32(32'd3, 32'd5, 1'b0, 0, "u3x5");
    check("u3x5_lit", {hi32, lo32}, 64'h0000_0000_0000_000F);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "umax");
    check("umax_lit", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    op32(32'hFFFF_FFFE, 32'd3, 1'b1, 0, "s_m2x3");
    check("s_m2x3_lit", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFFA);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "s_m1xm1");
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s_minxmin");
    check("s_minxmin_lit", {hi32, lo32}, 64'h4000_0000_0000_0000);
    op32(32'h8000_0000, 32'd1, 1'b1, 0, "s_minx1");
    check("s_minx1_lit", {hi32, lo32}, 64'hFFFF_FFFF_8000_0000);

    // Start while busy is dropped; start in the done cycle is accepted.
    op32(32'd7, 32'd9, 1'b0, 9, "ign7x9");
    check("ign7x9_lit", {hi32, lo32}, 64'd63);
    op32(32'd4, 32'd4, 1'b0, 0, "b2b4x4");
    check("b2b4x4_lit", 64'(lo32), 64'd16);

    // Abort mid-operation with asynchronous reset.
    op32(32'd6, 32'd7, 1'b0, 0, "pre6x7");
    start32 = 1'b1; a32 = 32'd100; b32 = 32'd100; signed32 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_hold_lo", 64'(lo32), 64'd42);
    check("abort_busy_pre", 64'(busy32), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    check("abort_prod", {hi32, lo32}, 64'd0);
    $display("abort32 reset during 100x100 -> busy=%0d done=%0d hi=%08h lo=%08h",
             busy32, done32, hi32, lo32);
    @(negedge clk);
    reset = 1'b0;
    op32(32'd2, 32'd3, 1'b0, 0, "post2x3");
    check("post2x3_lit", 64'(lo32), 64'd6);

    for (int i = 0; i < 16; i++) begin
      op32(pick32(), pick32(), 1'($urandom_range(0, 1)), 0, $sformatf("rnd32_%0d", i));
    end

    op8(8'h80, 8'h7F, 1'b1, "s8_minxmax");
    check("s8_minxmax_lit", 64'({hi8, lo8}), 64'hC080);
    op8(8'hFF, 8'hFF, 1'b0, "u8_max");
    check("u8_max_lit", 64'({hi8, lo8}), 64'hFE01);
    for (int i = 0; i < 16; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd8_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
